axis_video_pattern_gen: RTL
===========================

AXIS_VIDEO_PATTERN_GEN -- requirements
Module: axis_video_pattern_gen

Interface
REQ-001 SHALL provide parameter N, default 2: tdata width in bytes; one pixel per beat.
REQ-002 SHALL provide parameter WIDTH, default 16: pixels per line, at least 2.
REQ-003 SHALL provide parameter HEIGHT, default 8: lines per frame, at least 2.
REQ-004 SHALL provide parameter BLANK, default 4: idle cycles between frames, at least 0.
REQ-005 SHALL provide the following ports:
- aclk in 1: the single clock; all logic is on the rising edge.
- aresetn in 1: asynchronous, active-low reset.
- enable in 1: request frame generation.
- tvalid out 1: AXI4-Stream valid.
- tready in 1: AXI4-Stream ready.
- tdata out 8*N: pixel value.
- tlast out 1: end of line, asserted on the last pixel of every line.
- tuser out 1: start of frame, asserted on pixel (0,0) only.
- frame_done out 1: one-cycle pulse on the final pixel handshake of a frame.
- busy out 1: high while in RUN or BLANK.
REQ-006 SHALL treat reset as fixed: one clock aclk; asynchronous active-low reset aresetn.

Function
REQ-007 SHALL implement states IDLE, RUN and BLANK.
REQ-008 SHALL move from IDLE to RUN on the first cycle enable is sampled high, with x=0 and y=0.
REQ-009 SHALL assert tvalid in RUN only, and hold tvalid and tdata/tlast/tuser stable until tready is sampled high.
REQ-010 SHALL count a beat only on a handshake: tvalid and tready high on the same edge.
REQ-011 SHALL advance x on each beat; at x=WIDTH-1, x wraps to 0 and y increments.
REQ-012 SHALL drive tdata = (y*WIDTH + x), zero-extended or truncated modulo 2^(8N).
REQ-013 SHALL drive tlast = (x==WIDTH-1) and tuser = (x==0 && y==0) while tvalid is high; both SHALL be 0 otherwise.
REQ-014 SHALL, on the beat at x=WIDTH-1, y=HEIGHT-1:
- pulse frame_done for exactly that cycle;
- reset x and y to 0;
- enter BLANK if BLANK>0, otherwise re-evaluate enable immediately (REQ-016).
REQ-015 SHALL hold tvalid low in BLANK for exactly BLANK cycles, counted by a blank counter.
REQ-016 SHALL, at the end of BLANK (or on frame end when BLANK=0), enter RUN with tvalid high on the next cycle if enable is high, otherwise enter IDLE.
REQ-017 SHALL ignore enable deassertion mid-frame; the current frame always completes.
REQ-018 SHALL add no pipeline bubble: with tready held high, one beat per cycle within a frame.
REQ-019 SHALL drive tvalid low, with tdata/tlast/tuser at 0, whenever not in RUN.

Reset
REQ-020 SHALL, while aresetn is low, immediately force:
- state to IDLE;
- x, y, the blank counter and the frame counter to 0;
- tvalid, tlast, tuser, frame_done and busy to 0;
- tdata to 0.
REQ-021 SHALL abandon an in-progress frame on reset; after release, the next frame starts at (0,0) with tuser asserted.

Configuration
REQ-022 SHALL recognise the macro AXIS_VIDEO_PATTERN_GEN_FRAME_CNT_EN:
- Defined: keep a frame counter (8N bits, incremented at each frame_done, wrapping modulo 2^(8N)); tdata = (frame_count + y*WIDTH + x) mod 2^(8N).
- Undefined: no frame counter; tdata per REQ-012, identical for every frame.

Verification
REQ-023 SHALL verify basic frame generation: defaults, enable held high, tready held high -> 128 beats in 128 cycles; tdata 0..127; tlast on beats 15, 31, ... 127; tuser on beat 0 only; frame_done on beat 127; then 4 cycles of tvalid low; the next frame restarts at 0.
REQ-024 SHALL verify backpressure: tready toggling 1,0,0,1 repeating -> tdata, tlast and tuser remain stable while tvalid=1 and tready=0; the captured sequence equals 0..127 with no loss or duplication.
REQ-025 SHALL verify enable dropped mid-frame: enable deasserted at beat 40 -> the frame completes through beat 127, 4 blank cycles follow, then IDLE with busy=0.
REQ-026 SHALL verify reset mid-frame: aresetn pulsed low at beat 70 -> tvalid drops asynchronously; after release with enable high, the first beat is tdata=0 with tuser=1.
REQ-027 SHALL verify the frame counter option: AXIS_VIDEO_PATTERN_GEN_FRAME_CNT_EN defined, 3 frames -> the first pixel of frames 0, 1, 2 is 0, 1, 2; without the macro, each is 0.
REQ-028 SHALL verify zero blanking: BLANK=0 with WIDTH=2, HEIGHT=2 -> continuous beats 0,1,2,3,0,1,... with no idle cycle between frames; frame_done every 4th beat.

Source files
------------

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream video test pattern source: raster ramp, one pixel per beat.
// Define AXIS_VIDEO_PATTERN_GEN_FRAME_CNT_EN to add a per-frame offset to tdata.
module axis_video_pattern_gen #(
    parameter int N      = 2,
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 8,
    parameter int BLANK  = 4
) (
    input  logic           aclk,
    input  logic           aresetn,
    input  logic           enable,
    output logic           tvalid,
    input  logic           tready,
    output logic [8*N-1:0] tdata,
    output logic           tlast,
    output logic           tuser,
    output logic           frame_done,
    output logic           busy
);

    localparam int DW = 8 * N;
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int BW = (BLANK > 1) ? $clog2(BLANK) : 1;

    localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);
    localparam logic [BW-1:0] BMAX = BW'(BLANK - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_BLANK
    } state_t;

    state_t        r_state;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [BW-1:0] r_blank;
    logic [DW-1:0] r_idx;
    logic          r_tvalid;
    logic [DW-1:0] r_tdata;
    logic          r_tlast;
    logic          r_tuser;
    logic          r_eof;
    logic          r_busy;

    logic [XW-1:0] w_nx;
    logic [YW-1:0] w_ny;
    logic          w_x_end;
    logic          w_done;
    logic [DW-1:0] w_base;
    logic [DW-1:0] w_base_nx;

    assign w_x_end = (r_x == XMAX);
    assign w_nx    = w_x_end ? '0 : r_x + 1'b1;
    assign w_ny    = w_x_end ? r_y + 1'b1 : r_y;
    assign w_done  = r_tvalid & tready & r_eof;

`ifdef AXIS_VIDEO_PATTERN_GEN_FRAME_CNT_EN
    logic [DW-1:0] r_fcnt;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_fcnt <= '0;
        end else if (w_done) begin
            r_fcnt <= r_fcnt + 1'b1;
        end
    end

    // w_base_nx is the offset of a frame that starts on the same edge
    // that retires the previous one (counter not yet visible).
    assign w_base    = r_fcnt;
    assign w_base_nx = r_fcnt + 1'b1;
`else
    assign w_base    = '0;
    assign w_base_nx = '0;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= S_IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_blank  <= '0;
            r_idx    <= '0;
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
            r_tuser  <= 1'b0;
            r_eof    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state  <= S_RUN;
                        r_busy   <= 1'b1;
                        r_x      <= '0;
                        r_y      <= '0;
                        r_idx    <= '0;
                        r_tvalid <= 1'b1;
                        r_tdata  <= w_base;
                        r_tlast  <= 1'b0;
                        r_tuser  <= 1'b1;
                        r_eof    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (tready) begin
                        if (r_eof) begin
                            r_x   <= '0;
                            r_y   <= '0;
                            r_idx <= '0;
                            r_eof <= 1'b0;
                            if (BLANK > 0) begin
                                r_state  <= S_BLANK;
                                r_blank  <= '0;
                                r_tvalid <= 1'b0;
                                r_tdata  <= '0;
                                r_tlast  <= 1'b0;
                                r_tuser  <= 1'b0;
                            end else if (enable) begin
                                r_tdata <= w_base_nx;
                                r_tlast <= 1'b0;
                                r_tuser <= 1'b1;
                            end else begin
                                r_state  <= S_IDLE;
                                r_busy   <= 1'b0;
                                r_tvalid <= 1'b0;
                                r_tdata  <= '0;
                                r_tlast  <= 1'b0;
                                r_tuser  <= 1'b0;
                            end
                        end else begin
                            r_x     <= w_nx;
                            r_y     <= w_ny;
                            r_idx   <= r_idx + 1'b1;
                            r_tdata <= w_base + r_idx + 1'b1;
                            r_tlast <= (w_nx == XMAX);
                            r_tuser <= 1'b0;
                            r_eof   <= (w_nx == XMAX) && (w_ny == YMAX);
                        end
                    end
                end
                S_BLANK: begin
                    if (r_blank == BMAX) begin
                        r_blank <= '0;
                        if (enable) begin
                            r_state  <= S_RUN;
                            r_tvalid <= 1'b1;
                            r_tdata  <= w_base;
                            r_tlast  <= 1'b0;
                            r_tuser  <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_blank <= r_blank + 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_tvalid <= 1'b0;
                end
            endcase
        end
    end

    assign tvalid     = r_tvalid;
    assign tdata      = r_tdata;
    assign tlast      = r_tlast;
    assign tuser      = r_tuser;
    assign frame_done = w_done;
    assign busy       = r_busy;

endmodule
